// File: rtl/gfx_mem_arbiter_if.sv
// Bus bundle for gfx_mem_arbiter: requester rts/rtr streams, memory slot, read broadcast.
// master = arbiter view, slave = engines/memory view.
interface gfx_mem_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_rts;
  logic [NUM_REQ-1:0]    req_rtr;
  logic [4*NUM_REQ-1:0]  req_wben;
  logic [16*NUM_REQ-1:0] req_addr;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_op;
  logic                  mem_out_rts;
  logic                  mem_in_rtr;
  logic [3:0]            mem_out_wben;
  logic [15:0]           mem_out_addr;
  logic [31:0]           mem_out_data;
  logic                  mem_out_op;
  logic [31:0]           mem_in_rd_data;
  logic                  mem_in_rd_valid;
  logic [31:0]           arb_bcast_out_data;
  logic                  arb_bcast_out_xfc;
  logic [1:0]            grant_idx;
  logic                  arb_busy;

  modport master (
    input  req_rts, req_wben, req_addr, req_data, req_op,
    input  mem_in_rtr, mem_in_rd_data, mem_in_rd_valid,
    output req_rtr, mem_out_rts, mem_out_wben, mem_out_addr, mem_out_data, mem_out_op,
    output arb_bcast_out_data, arb_bcast_out_xfc, grant_idx, arb_busy
  );

  modport slave (
    output req_rts, req_wben, req_addr, req_data, req_op,
    output mem_in_rtr, mem_in_rd_data, mem_in_rd_valid,
    input  req_rtr, mem_out_rts, mem_out_wben, mem_out_addr, mem_out_data, mem_out_op,
    input  arb_bcast_out_data, arb_bcast_out_xfc, grant_idx, arb_busy
  );
endinterface

// File: rtl/gfx_mem_arbiter.sv
// Round-robin arbiter sharing one frame-buffer port between up to four graphics engines.
// Define MEM_ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST beats.
module gfx_mem_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input logic               clk,
  input logic               rst_,
  gfx_mem_arbiter_if.master bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  pick_s;
  logic        any_rts_s;
  logic        rtr_g_s;
  logic        xfc_in_s;
  logic        xfc_out_s;
  logic        slot_vld_q;
  logic [3:0]  wben_q;
  logic [15:0] addr_q;
  logic [31:0] data_q;
  logic        op_q;
  logic [31:0] bcast_data_q;
  logic        bcast_xfc_q;
`ifdef MEM_ARB_BURST_LIMIT_EN
  logic [15:0] burst_cnt_q, burst_cnt_d;
`endif

  // Round-robin pick: iterate farthest-to-nearest so the nearest requester after rr_ptr wins.
  always_comb begin
    int         cand;
    logic [1:0] cand_s;
    cand      = 0;
    cand_s    = rr_ptr_q;
    pick_s    = rr_ptr_q;
    any_rts_s = |bus.req_rts;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand   = int'(rr_ptr_q) + k;
      cand   = (cand >= NUM_REQ) ? cand - NUM_REQ : cand;
      cand_s = 2'(cand);
      pick_s = bus.req_rts[cand_s] ? cand_s : pick_s;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= IDLE;
      grant_q  <= 2'd0;
      rr_ptr_q <= 2'(NUM_REQ - 1);
`ifdef MEM_ARB_BURST_LIMIT_EN
      burst_cnt_q <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef MEM_ARB_BURST_LIMIT_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  // Next-state: grant from IDLE, release on rts drop (or on the last beat of a capped burst).
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
`ifdef MEM_ARB_BURST_LIMIT_EN
    burst_cnt_d = burst_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_rts_s) begin
          grant_d = pick_s;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!bus.req_rts[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = grant_q;
`ifdef MEM_ARB_BURST_LIMIT_EN
          burst_cnt_d = 16'd0;
        end else if (xfc_in_s && (burst_cnt_q == 16'(MAX_BURST - 1))) begin
          state_d     = IDLE;
          rr_ptr_d    = grant_q;
          burst_cnt_d = 16'd0;
        end else if (xfc_in_s) begin
          burst_cnt_d = burst_cnt_q + 16'd1;
`endif
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: only the grantee sees rtr, and only while the slot can take a beat this cycle.
  always_comb begin
    bus.req_rtr = '0;
    rtr_g_s     = ~slot_vld_q | bus.mem_in_rtr;
    xfc_in_s    = 1'b0;
    case (state_q)
      BUSY: begin
        bus.req_rtr[grant_q] = rtr_g_s;
        xfc_in_s             = bus.req_rts[grant_q] & rtr_g_s;
      end
      IDLE: begin
        bus.req_rtr = '0;
        xfc_in_s    = 1'b0;
      end
      default: begin
        bus.req_rtr = '0;
        xfc_in_s    = 1'b0;
      end
    endcase
  end

  assign xfc_out_s = slot_vld_q & bus.mem_in_rtr;

  // One-entry output slot; a simultaneous load and drain keeps it full with no bubble.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      slot_vld_q <= 1'b0;
      wben_q     <= 4'd0;
      addr_q     <= 16'd0;
      data_q     <= 32'd0;
      op_q       <= 1'b0;
    end else if (xfc_in_s) begin
      slot_vld_q <= 1'b1;
      wben_q     <= bus.req_wben[{grant_q, 2'b00} +: 4];
      addr_q     <= bus.req_addr[{grant_q, 4'b0000} +: 16];
      data_q     <= bus.req_data[{grant_q, 5'b00000} +: 32];
      op_q       <= bus.req_op[grant_q];
    end else if (xfc_out_s) begin
      slot_vld_q <= 1'b0;
    end else begin
      slot_vld_q <= slot_vld_q;
    end
  end

  // Read-return broadcast register; data holds between strobes.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      bcast_data_q <= 32'd0;
      bcast_xfc_q  <= 1'b0;
    end else begin
      bcast_xfc_q  <= bus.mem_in_rd_valid;
      bcast_data_q <= bus.mem_in_rd_valid ? bus.mem_in_rd_data : bcast_data_q;
    end
  end

  assign bus.mem_out_rts        = slot_vld_q;
  assign bus.mem_out_wben       = wben_q;
  assign bus.mem_out_addr       = addr_q;
  assign bus.mem_out_data       = data_q;
  assign bus.mem_out_op         = op_q;
  assign bus.arb_bcast_out_data = bcast_data_q;
  assign bus.arb_bcast_out_xfc  = bcast_xfc_q;
  assign bus.grant_idx          = grant_q;
  assign bus.arb_busy           = (state_q == BUSY);

endmodule

// File: doc/gfx_mem_arbiter.md
# gfx_mem_arbiter

Shares the single frame-buffer memory port between up to four graphics data-generation engines (fill-rect, line, blit, clear). Each engine presents an rts/rtr write/read request stream; the arbiter grants one engine at a time with round-robin fairness. It holds the grant for a burst, registers the selected beat into a one-entry output slot toward memory, and broadcasts memory read-return data back to all engines.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters. Legal range is 2..4.
- MAX_BURST, 16: maximum beats per grant. Used only when the burst limit is compiled in. Legal range is 1..65535.

Ports:
- clk  in  1  Single clock for the whole block.
- rst_  in  1  Reset, asynchronous, active-low.
- req_rts  in  NUM_REQ  Per-requester ready-to-send.
- req_rtr  out  NUM_REQ  Per-requester ready-to-receive.
- req_wben  in  4*NUM_REQ  Byte enables. Requester i uses bits [4i+3:4i].
- req_addr  in  16*NUM_REQ  Word address. Requester i uses bits [16i+15:16i].
- req_data  in  32*NUM_REQ  Write data. Requester i uses bits [32i+31:32i].
- req_op  in  NUM_REQ  Operation: 0 = write, 1 = read.
- mem_out_rts  out  1  Output slot holds a valid beat.
- mem_in_rtr  in  1  Memory accepts the beat.
- mem_out_wben  out  4  Registered payload.
- mem_out_addr  out  16  Registered payload.
- mem_out_data  out  32  Registered payload.
- mem_out_op  out  1  Registered payload.
- mem_in_rd_data  in  32  Read return data.
- mem_in_rd_valid  in  1  Read return strobe.
- arb_bcast_out_data  out  32  Registered read data, sent to all requesters.
- arb_bcast_out_xfc  out  1  One-cycle strobe for the broadcast data.
- grant_idx  out  2  Index of the current or most recent grantee.
- arb_busy  out  1  High while the state machine is in BUSY.

## Operation
- States are IDLE and BUSY.
- Reset state: IDLE; rr_ptr = NUM_REQ-1; burst_cnt = 0; slot empty.
- IDLE:
  - If any req_rts bit is high, select the first set bit searching from (rr_ptr+1) mod NUM_REQ upward, with wrap.
  - Register the selection into grant_idx and go to BUSY.
  - No transfer occurs in IDLE.
- BUSY, with g = grant_idx:
  - req_rtr[g] = (!mem_out_rts | mem_in_rtr). All other req_rtr bits are 0. req_rtr is 0 in IDLE.
  - Requester transfer xfc_in = req_rts[g] & req_rtr[g]. On xfc_in, load requester g's payload into the slot and set slot valid.
  - Memory transfer xfc_out = mem_out_rts & mem_in_rtr. On xfc_out without xfc_in, clear slot valid.
  - When xfc_in and xfc_out occur together, the slot stays valid and takes the new payload. There is no bubble.
  - If req_rts[g] is 0: go to IDLE, set rr_ptr = g, clear burst_cnt.
- mem_out_rts is the slot valid bit. The payload must be held stable while mem_out_rts=1 and mem_in_rtr=0.
- Read return: on mem_in_rd_valid, the next cycle has arb_bcast_out_data = mem_in_rd_data and arb_bcast_out_xfc = 1. Otherwise xfc = 0 and the data holds its last value.
- Requesters filter broadcasts themselves. The arbiter does not tag read returns.
- Payload is passed through unmodified. No address arithmetic is done here.

## Timing
- req_rts rising while in IDLE → grant_idx valid and req_rtr[g] high on the next edge.
  - First xfc_in occurs in that cycle.
  - The beat appears on mem_out on the following edge.
  - Latency from first req_rts to mem_out_rts is 2 cycles.
- Steady state: 1 beat per cycle while mem_in_rtr=1.
- Every grant change passes through one IDLE cycle, so re-arbitration costs one bubble.
- A requester dropping req_rts costs the one cycle in which BUSY detects the drop.
- The slot may drain in IDLE: xfc_out still clears it.
- Reset values: all outputs 0 (mem_out_*, req_rtr, arb_bcast_*, grant_idx, arb_busy).
- Reset mid-operation: the slot contents and any in-flight grant are discarded. After release, requester 0 has first priority.

## Configuration
- Macro MEM_ARB_BURST_LIMIT_EN.
- Defined:
  - burst_cnt (16 bits) increments on each xfc_in.
  - On an xfc_in with burst_cnt == MAX_BURST-1: go to IDLE, set rr_ptr = g, clear burst_cnt, even if req_rts[g] is still high.
- Undefined: there is no burst counter. A grant is held until req_rts[g] drops, so one engine can hold the port indefinitely.

## Test plan
- Single requester: req 0 rts for 3 beats with addr 0x0010/0x0011/0x0012 and mem_in_rtr=1 → grant_idx=0 one cycle later; mem_out_addr shows 0x0010..0x0012 on consecutive cycles starting 2 cycles after rts; arb_busy drops one cycle after rts falls.
- Fairness (macro on, MAX_BURST=4): reqs 0 and 2 rts continuously → mem_out shows beats in groups of 4, in order 0,2,0,2, with exactly one idle cycle between groups.
- Backpressure: mem_in_rtr=0 for 3 cycles while the slot holds data 0xA5A5A5A5 → req_rtr[g]=0 and the payload is stable; after rtr returns, no beat is lost or duplicated.
- Read broadcast: mem_in_rd_valid=1 with 0xDEADBEEF → next cycle arb_bcast_out_xfc=1 and data=0xDEADBEEF; xfc=0 the cycle after.
- Reset mid-burst: assert rst_ during a req 1 burst → all outputs go to 0 immediately; after release, with reqs 0 and 1 both rts, req 0 is granted first.
- Macro off: req 1 rts for 40 beats while req 0 also requests → req 0 gets no grant until req 1 drops rts, then req 0 is granted after one IDLE cycle.
